ring_fsm_param: RTL and testbench

Parametrised ring state machine, successor to the fixed 4-state control FSM. NUM_STATES one-hot states visited in a ring: 0 -> 1 -> ... -> NUM_STATES-1 -> 0. Each state advances on its own request bit; states flagged in TIMED_MASK also auto-advance after DWELL cycles. A DATA_W-bit activity counter is steered to one of two data outputs by a latched select, with abort and wrap-indication added.

---
 rtl/ring_fsm_param.sv | 111 +++++++++++
 tb/tb_ring_fsm_param.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ring_fsm_param.sv
// ring_fsm_param: parametrised one-hot ring controller with timed states,
// abort, wrap pulse and a select-steered activity counter.
module ring_fsm_param #(
  parameter int unsigned                 NUM_STATES = 4,
  parameter int unsigned                 DATA_W     = 8,
  parameter int unsigned                 DWELL      = 16,
  parameter logic [NUM_STATES-1:0]       TIMED_MASK = 'b0100
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_STATES-1:0]         i_adv,
  input  logic                          i_abort,
  input  logic                          i_sel,
  input  logic                          i_sel_valid,
  output logic [NUM_STATES-1:0]         state,
  output logic [$clog2(NUM_STATES)-1:0] o_state_idx,
  output logic [DATA_W-1:0]             o_data1,
  output logic [DATA_W-1:0]             o_data2,
  output logic                          o_wrap
);

  localparam int unsigned IW = $clog2(NUM_STATES);
  localparam int unsigned DW = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [IW-1:0] LAST_IDX  = IW'(NUM_STATES - 1);
  localparam logic [DW-1:0] DWELL_END = DW'(DWELL - 1);

  logic [NUM_STATES-1:0] state_q, state_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic [DW-1:0]         dwell_q, dwell_d;
  logic [DATA_W-1:0]     cnt_q, cnt_d;
  logic [DATA_W-1:0]     data1_q, data1_d;
  logic [DATA_W-1:0]     data2_q, data2_d;
  logic                  wrap_q, wrap_d;
  logic                  sel_q;
  logic                  adv;

  // Binary index is registered next to the one-hot vector so both always agree.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= NUM_STATES'(1);
      idx_q   <= '0;
      dwell_q <= '0;
      cnt_q   <= '0;
      data1_q <= '0;
      data2_q <= '0;
      wrap_q  <= 1'b0;
      sel_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      dwell_q <= dwell_d;
      cnt_q   <= cnt_d;
      data1_q <= data1_d;
      data2_q <= data2_d;
      wrap_q  <= wrap_d;
      if (i_sel_valid) begin
        sel_q <= i_sel;
      end
    end
  end

  assign adv = i_adv[idx_q] | (TIMED_MASK[idx_q] & (dwell_q == DWELL_END));

  // Abort beats advance beats hold; the counter runs in every state but 0.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    dwell_d = dwell_q;
    cnt_d   = cnt_q;
    data1_d = data1_q;
    data2_d = data2_q;
    wrap_d  = 1'b0;
    if (i_abort) begin
      state_d = NUM_STATES'(1);
      idx_d   = '0;
      cnt_d   = '0;
      dwell_d = '0;
    end else begin
      if (idx_q != '0) begin
        cnt_d = cnt_q + 1'b1;
        if (sel_q) begin
          data2_d = cnt_q + 1'b1;
        end else begin
          data1_d = cnt_q + 1'b1;
        end
      end
      if (adv) begin
        state_d = {state_q[NUM_STATES-2:0], state_q[NUM_STATES-1]};
        dwell_d = '0;
        if (idx_q == LAST_IDX) begin
          idx_d  = '0;
          wrap_d = 1'b1;
          cnt_d  = '0;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end else if (TIMED_MASK[idx_q]) begin
        dwell_d = dwell_q + 1'b1;
      end else begin
        dwell_d = '0;
      end
    end
  end

  assign state       = state_q;
  assign o_state_idx = idx_q;
  assign o_data1     = data1_q;
  assign o_data2     = data2_q;
  assign o_wrap      = wrap_q;

endmodule

// File: tb/tb_ring_fsm_param.sv
// Directed bench for ring_fsm_param with default parameters.
module tb_ring_fsm_param;

  logic       clk;
  logic       rst;
  logic [3:0] i_adv;
  logic       i_abort;
  logic       i_sel;
  logic       i_sel_valid;
  logic [3:0] state;
  logic [1:0] o_state_idx;
  logic [7:0] o_data1;
  logic [7:0] o_data2;
  logic       o_wrap;

  int errors = 0;
  int checks = 0;

  ring_fsm_param #(
    .NUM_STATES(4),
    .DATA_W(8),
    .DWELL(16),
    .TIMED_MASK(4'b0100)
  ) dut (
    .clk(clk),
    .rst(rst),
    .i_adv(i_adv),
    .i_abort(i_abort),
    .i_sel(i_sel),
    .i_sel_valid(i_sel_valid),
    .state(state),
    .o_state_idx(o_state_idx),
    .o_data1(o_data1),
    .o_data2(o_data2),
    .o_wrap(o_wrap)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b0; i_adv = '0; i_abort = 0; i_sel = 0; i_sel_valid = 0;
    tick(4);
    rst = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick(1);
      checks++;
      if (state !== 4'b0001 || o_state_idx !== 2'd0) begin
        errors++;
        $display("FAIL reset_state: state=%b idx=%0d expected 0001/0", state, o_state_idx);
      end
      checks++;
      if (o_data1 !== 8'd0 || o_data2 !== 8'd0 || o_wrap !== 1'b0) begin
        errors++;
        $display("FAIL reset_data: d1=%0d d2=%0d wrap=%b expected 0/0/0", o_data1, o_data2, o_wrap);
      end
    end
  endtask

  task automatic test_sel_adv();
    i_sel = 1; i_sel_valid = 1;
    tick(1);
    i_sel = 0; i_sel_valid = 0; i_adv = 4'b0001;
    tick(1);
    i_adv = '0;
    checks++;
    if (state !== 4'b0010 || o_state_idx !== 2'd1) begin
      errors++;
      $display("FAIL adv0: state=%b idx=%0d expected 0010/1", state, o_state_idx);
    end
    for (int k = 1; k <= 5; k++) begin
      tick(1);
      checks++;
      if (o_data2 !== 8'(k) || o_data1 !== 8'd0) begin
        errors++;
        $display("FAIL count_ch2: d2=%0d d1=%0d expected %0d/0", o_data2, o_data1, k);
      end
    end
  endtask

  // Entered with state 1, cnt=5; leaves in state 3 with cnt=22.
  task automatic test_timed();
    i_adv = 4'b0010;
    tick(1);
    i_adv = '0;
    checks++;
    if (state !== 4'b0100) begin
      errors++;
      $display("FAIL enter_timed: state=%b expected 0100", state);
    end
    for (int i = 1; i <= 15; i++) begin
      tick(1);
      checks++;
      if (state !== 4'b0100) begin
        errors++;
        $display("FAIL dwell_hold: cycle %0d state=%b expected 0100", i, state);
      end
    end
    tick(1);
    checks++;
    if (state !== 4'b1000 || o_state_idx !== 2'd3) begin
      errors++;
      $display("FAIL dwell_expire: state=%b idx=%0d expected 1000/3", state, o_state_idx);
    end
    checks++;
    if (o_data2 !== 8'd22) begin
      errors++;
      $display("FAIL dwell_count: d2=%0d expected 22", o_data2);
    end
  endtask

  // From state 3 with cnt=22: wrap, then restart the count.
  task automatic test_wrap();
    i_adv = 4'b1000;
    tick(1);
    i_adv = '0;
    checks++;
    if (state !== 4'b0001 || o_wrap !== 1'b1 || o_data2 !== 8'd23) begin
      errors++;
      $display("FAIL wrap_edge: state=%b wrap=%b d2=%0d expected 0001/1/23", state, o_wrap, o_data2);
    end
    for (int i = 0; i < 3; i++) begin
      tick(1);
      checks++;
      if (o_wrap !== 1'b0 || o_data2 !== 8'd23 || state !== 4'b0001) begin
        errors++;
        $display("FAIL wrap_after: wrap=%b d2=%0d state=%b expected 0/23/0001", o_wrap, o_data2, state);
      end
    end
    i_adv = 4'b0001;
    tick(1);
    i_adv = '0;
    tick(1);
    checks++;
    if (o_data2 !== 8'd1) begin
      errors++;
      $display("FAIL restart: d2=%0d expected 1", o_data2);
    end
  endtask

  // From state 1 with cnt=1: early advance out of the timed state.
  task automatic test_early_adv();
    i_adv = 4'b0010;
    tick(1);
    i_adv = '0;
    tick(4);
    checks++;
    if (state !== 4'b0100) begin
      errors++;
      $display("FAIL early_pre: state=%b expected 0100", state);
    end
    i_adv = 4'b0100;
    tick(1);
    i_adv = '0;
    checks++;
    if (state !== 4'b1000 || o_data2 !== 8'd7) begin
      errors++;
      $display("FAIL early_adv: state=%b d2=%0d expected 1000/7", state, o_data2);
    end
    tick(3);
    checks++;
    if (state !== 4'b1000 || o_data2 !== 8'd10) begin
      errors++;
      $display("FAIL untimed_hold: state=%b d2=%0d expected 1000/10", state, o_data2);
    end
    i_adv = 4'b1000;
    tick(1);
    i_adv = '0;
    checks++;
    if (state !== 4'b0001 || o_wrap !== 1'b1 || o_data2 !== 8'd11) begin
      errors++;
      $display("FAIL wrap2: state=%b wrap=%b d2=%0d expected 0001/1/11", state, o_wrap, o_data2);
    end
  endtask

  task automatic test_ignore_abort();
    i_adv = 4'b0001;
    tick(1);
    i_adv = 4'b0100;
    tick(2);
    checks++;
    if (state !== 4'b0010 || o_data2 !== 8'd2) begin
      errors++;
      $display("FAIL ignore_other: state=%b d2=%0d expected 0010/2", state, o_data2);
    end
    i_abort = 1; i_adv = 4'b0010;
    tick(1);
    i_abort = 0; i_adv = '0;
    checks++;
    if (state !== 4'b0001 || o_state_idx !== 2'd0 || o_wrap !== 1'b0 || o_data2 !== 8'd2) begin
      errors++;
      $display("FAIL abort: state=%b idx=%0d wrap=%b d2=%0d expected 0001/0/0/2",
               state, o_state_idx, o_wrap, o_data2);
    end
    tick(2);
    checks++;
    if (state !== 4'b0001 || o_data2 !== 8'd2) begin
      errors++;
      $display("FAIL abort_hold: state=%b d2=%0d expected 0001/2", state, o_data2);
    end
  endtask

  task automatic test_async_reset();
    i_adv = 4'b0001;
    tick(1);
    i_adv = 4'b0010;
    tick(1);
    i_adv = '0;
    tick(2);
    checks++;
    if (state !== 4'b0100) begin
      errors++;
      $display("FAIL pre_reset: state=%b expected 0100", state);
    end
    #2 rst = 1'b0;
    #1;
    checks++;
    if (state !== 4'b0001 || o_state_idx !== 2'd0 || o_data1 !== 8'd0 ||
        o_data2 !== 8'd0 || o_wrap !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: state=%b idx=%0d d1=%0d d2=%0d wrap=%b expected 0001/0/0/0/0",
               state, o_state_idx, o_data1, o_data2, o_wrap);
    end
    tick(1);
    rst = 1'b1;
  endtask

  // sel_r is 0 after reset, so channel 1 counts.
  task automatic test_counter_wrap();
    i_adv = 4'b0001;
    tick(1);
    i_adv = '0;
    for (int i = 1; i <= 300; i++) begin
      tick(1);
      checks++;
      if (o_data1 !== 8'(i % 256) || o_data2 !== 8'd0) begin
        errors++;
        $display("FAIL cnt_wrap: cycle %0d d1=%0d d2=%0d expected %0d/0",
                 i, o_data1, o_data2, i % 256);
      end
    end
    checks++;
    if (state !== 4'b0010) begin
      errors++;
      $display("FAIL stay_s1: state=%b expected 0010", state);
    end
  endtask

  initial begin
    test_reset();
    test_sel_adv();
    test_timed();
    test_wrap();
    test_early_adv();
    test_ignore_abort();
    test_async_reset();
    test_counter_wrap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
